// File: rtl/wfg_pat_drive.sv
// Pattern driver downstream of the wfg core: steps through a window of pattern
// words on each core sync pulse and presents them on a valid/ready stream.
// Optional loop counter output enabled by defining WFG_PAT_DRIVE_LOOPCNT_EN.
module wfg_pat_drive #(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 16,
  localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [IW-1:0]             cfg_begin_i,
  input  logic [IW-1:0]             cfg_end_i,
  input  logic [DEPTH*CHANNELS-1:0] pattern_i,
  input  logic                      wfg_core_start_i,
  input  logic                      wfg_core_sync_i,
  input  logic                      wfg_core_active_i,
  output logic [CHANNELS-1:0]       pat_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      overrun_o,
  output logic                      active_o,
  output logic [IW-1:0]             idx_o
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
  ,
  output logic [15:0]               loop_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       begin_q, begin_d;
  logic [IW-1:0]       end_q, end_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CHANNELS-1:0] pat_q, pat_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                step;
  logic                wrap;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
  logic [15:0]         loop_q, loop_d;
`endif

  assign wrap = (idx_q == end_q);

  always_comb begin
    state_d = state_q;
    begin_d = begin_q;
    end_d   = end_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    step    = 1'b0;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
    loop_d  = loop_q;
`endif

    if (clr_i) ovr_d = 1'b0;
    if (valid_q && ready_i) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = ARMED;
          begin_d = cfg_begin_i;
          // A reversed window collapses to a single-word loop at begin.
          end_d   = (cfg_end_i < cfg_begin_i) ? cfg_begin_i : cfg_end_i;
          idx_d   = cfg_begin_i;
          ovr_d   = 1'b0;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
          loop_d  = '0;
`endif
        end
      end
      ARMED: begin
        if (!en_i) begin
          state_d = IDLE;
        end else if (wfg_core_start_i && wfg_core_active_i) begin
          state_d = RUN;
          step    = wfg_core_sync_i;
        end
      end
      RUN: begin
        if (!en_i || !wfg_core_active_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else begin
          step = wfg_core_sync_i;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides both the handshake clear and a same-cycle clr_i.
    if (step) begin
      pat_d   = pattern_i[int'(idx_q)*CHANNELS +: CHANNELS];
      valid_d = 1'b1;
      idx_d   = wrap ? begin_q : idx_q + 1'b1;
      if (valid_q && !ready_i) ovr_d = 1'b1;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
      if (wrap && (loop_q != '1)) loop_d = loop_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      begin_q <= '0;
      end_q   <= '0;
      idx_q   <= '0;
      pat_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
      loop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      begin_q <= begin_d;
      end_q   <= end_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
      loop_q  <= loop_d;
`endif
    end
  end

  assign pat_o     = pat_q;
  assign valid_o   = valid_q;
  assign overrun_o = ovr_q;
  assign active_o  = (state_q == RUN);
  assign idx_o     = idx_q;
`ifdef WFG_PAT_DRIVE_LOOPCNT_EN
  assign loop_cnt_o = loop_q;
`endif

endmodule

// File: doc/wfg_pat_drive.md
Name: wfg_pat_drive

Overview:
- Pattern driver that sits directly downstream of the wfg core.
- Consumes the core synchronisation outputs (start, sync, active) and steps through a configurable window of pattern words, one word per sync pulse.
- Presents each word as a CHANNELS-wide sample on a valid/ready stream toward the pin/driver stage.
- Flags overrun when the consumer has not taken a word before the next sync pulse.

Parameters:
- CHANNELS, 8, width of one pattern word (output pins).
- DEPTH, 16, number of pattern words; index width IW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en_i  input  1  block enable (level)
- clr_i  input  1  one-cycle pulse; clears overrun_o
- cfg_begin_i  input  IW  first pattern index
- cfg_end_i  input  IW  last pattern index (inclusive)
- pattern_i  input  DEPTH*CHANNELS  flattened words; word k = pattern_i[k*CHANNELS +: CHANNELS]
- wfg_core_start_i  input  1  one-cycle pulse from core, start of sequence
- wfg_core_sync_i  input  1  one-cycle pulse from core, advance one step
- wfg_core_active_i  input  1  core active level
- pat_o  output  CHANNELS  current sample
- valid_o  output  1  sample valid
- ready_i  input  1  consumer accepts sample when valid_o&ready_i
- overrun_o  output  1  sticky, sample replaced before accepted
- active_o  output  1  high while in RUN
- idx_o  output  IW  index of the word to be emitted next

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; idx, pat_o, valid_o, overrun_o, active_o all 0.
  - A reset mid-operation aborts immediately to these values.
- States:
  - IDLE -> ARMED when en_i=1. On this transition:
    - latch begin_q=cfg_begin_i;
    - latch end_q=max(cfg_end_i, cfg_begin_i), so end<begin gives a single-word loop;
    - idx<=begin_q;
    - overrun_o<=0.
  - Config inputs are ignored outside this transition.
  - ARMED -> RUN on wfg_core_start_i=1 while wfg_core_active_i=1.
  - ARMED -> IDLE on en_i=0.
  - RUN -> IDLE on en_i=0 or wfg_core_active_i=0 (evaluated every cycle, takes priority over sync). On entry to IDLE: valid_o<=0, pat_o holds its last value, active_o<=0.
- Stepping (RUN only):
  - Each cycle with wfg_core_sync_i=1, on the next clock edge:
    - pat_o<=word[idx], valid_o<=1;
    - idx<=(idx==end_q) ? begin_q : idx+1.
  - Latency is 1 cycle from sync to valid sample.
  - pattern_i is sampled at the sync cycle (live).
- Start/sync coincidence: a sync coincident with start in ARMED counts as the first step, i.e. word[begin] is emitted one cycle later.
- Handshake:
  - valid_o clears on the edge after valid_o&ready_i, unless a new sync loads a word in the same cycle (load wins, valid stays 1).
  - pat_o is stable while valid_o=1 and not accepted.
- Overrun:
  - A sync in RUN while valid_o=1 and ready_i=0 sets overrun_o=1 and replaces the word.
  - A sync with valid_o=1 and ready_i=1 in the same cycle is not an overrun.
  - overrun_o stays set until clr_i or re-arm. clr_i and a new overrun in the same cycle: set wins.
- Sync pulses in IDLE/ARMED (other than the coincident start case) are ignored.
- Index arithmetic is unsigned. idx never exceeds end_q, and begin_q=end_q=DEPTH-1 is legal.

Optional Feature:
- Macro: WFG_PAT_DRIVE_LOOPCNT_EN.
- Defined:
  - extra output loop_cnt_o[15:0], reset 0;
  - increments, saturating at 16'hFFFF, on each step where idx wraps from end_q to begin_q;
  - cleared on IDLE->ARMED.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Basic run: begin=2, end=4, ready_i=1, start then 4 sync pulses -> pat_o sequence word2, word3, word4, word2, each valid_o 1 cycle after sync; overrun_o=0.
- Backpressure: ready_i=0, two syncs 5 cycles apart -> second word replaces first, overrun_o=1. Then clr_i -> overrun_o=0. Then ready_i=1 -> valid_o drops the next cycle.
- Reversed window and single word: begin=5, end=3 -> every sync emits word5, idx_o stays 5. Begin=end=15 (DEPTH=16) -> word15 repeated, no index overflow.
- Start/sync coincidence and pre-start syncs: syncs while ARMED without start -> no valid_o. Start and sync in the same cycle -> word[begin] valid 1 cycle later.
- Abort: wfg_core_active_i drops mid-RUN with valid_o=1 -> IDLE next edge, valid_o=0, pat_o held. Asserting rst_n=0 asynchronously mid-stream -> all outputs 0 without waiting for a clock edge.
- Loop counter (WFG_PAT_DRIVE_LOOPCNT_EN defined): begin=0, end=1, 7 syncs -> loop_cnt_o=3. Re-arm -> 0.
